// File: rtl/insn_mem_bridge_if.sv
// Fetch-side and memory-side signals of the instruction bridge.
// The bridge takes the slave view; the core/memory environment takes the master view.
interface insn_mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INSN_WIDTH = 32
) ();
  logic                    fetch_en;
  logic [ADDR_WIDTH-1:2]   fetch_addr;
  logic                    fetch_busy;
  logic                    fetched_valid;
  logic [INSN_WIDTH-1:0]   fetched_insn;
  logic [ADDR_WIDTH-1:2]   fetched_addr;
  logic                    flush;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:2]   mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [INSN_WIDTH-1:0]   mem_rdata;
  logic                    overflow;
  logic                    protocol_err;

  modport slave (
    input  fetch_en, fetch_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    output fetch_busy, fetched_valid, fetched_insn, fetched_addr,
           mem_req, mem_addr, overflow, protocol_err
  );

  modport master (
    output fetch_en, fetch_addr, flush, mem_gnt, mem_rvalid, mem_rdata,
    input  fetch_busy, fetched_valid, fetched_insn, fetched_addr,
           mem_req, mem_addr, overflow, protocol_err
  );
endinterface

// File: rtl/insn_mem_bridge.sv
// Instruction-fetch to memory-bus bridge: buffers requests until granted, tracks
// granted requests in order, returns words one cycle after rvalid, and kills stale work on flush.
module insn_mem_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned REQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  insn_mem_bridge_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(REQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;

  typedef logic [WA_W-1:0] waddr_t;

  // request FIFO
  waddr_t           rq_addr [REQ_DEPTH];
  logic [PTR_W-1:0] rq_wr, rq_rd;
  logic [CNT_W-1:0] rq_cnt;

  // in-flight FIFO: address plus kill flag per entry
  waddr_t                fl_addr [REQ_DEPTH];
  logic [REQ_DEPTH-1:0]  fl_kill;
  logic [PTR_W-1:0]      fl_wr, fl_rd;
  logic [CNT_W-1:0]      fl_cnt;

  logic   rq_full, rq_empty, fl_full, fl_empty;
  logic   rq_push, req_c, issue, resp, resp_live, spurious;
  waddr_t rq_head;

  always_comb begin
    rq_full   = (rq_cnt == CNT_W'(REQ_DEPTH));
    rq_empty  = (rq_cnt == '0);
    fl_full   = (fl_cnt == CNT_W'(REQ_DEPTH));
    fl_empty  = (fl_cnt == '0);
    rq_head   = rq_addr[rq_rd];
    rq_push   = bus.fetch_en && !rq_full;
    req_c     = !rq_empty && !fl_full;
    issue     = req_c && bus.mem_gnt;
    resp      = bus.mem_rvalid && !fl_empty;
    resp_live = resp && !fl_kill[fl_rd] && !bus.flush;
    spurious  = bus.mem_rvalid && fl_empty;
  end

  // Request-side outputs depend only on registered state.
  assign bus.mem_req    = req_c;
  assign bus.mem_addr   = req_c ? rq_head : '0;
  assign bus.fetch_busy = rq_full;

  // Flush drops everything queued but still accepts this cycle's fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_wr  <= '0;
      rq_rd  <= '0;
      rq_cnt <= '0;
    end else if (bus.flush) begin
      rq_rd  <= rq_wr;
      rq_wr  <= rq_wr + PTR_W'(rq_push);
      rq_cnt <= CNT_W'(rq_push);
    end else begin
      rq_wr  <= rq_wr + PTR_W'(rq_push);
      rq_rd  <= rq_rd + PTR_W'(issue);
      rq_cnt <= rq_cnt + CNT_W'(rq_push) - CNT_W'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) rq_addr[rq_wr] <= bus.fetch_addr;
    if (issue)   fl_addr[fl_wr] <= rq_head;
  end

  // Flush marks every entry killed, including one granted in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_wr   <= '0;
      fl_rd   <= '0;
      fl_cnt  <= '0;
      fl_kill <= '0;
    end else begin
      fl_wr  <= fl_wr + PTR_W'(issue);
      fl_rd  <= fl_rd + PTR_W'(resp);
      fl_cnt <= fl_cnt + CNT_W'(issue) - CNT_W'(resp);
      if (bus.flush)  fl_kill        <= '1;
      else if (issue) fl_kill[fl_wr] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fetched_valid <= 1'b0;
      bus.fetched_insn  <= '0;
      bus.fetched_addr  <= '0;
      bus.overflow      <= 1'b0;
      bus.protocol_err  <= 1'b0;
    end else begin
      bus.fetched_valid <= resp_live;
      if (resp_live) begin
        bus.fetched_insn <= INSN_WIDTH'(bus.mem_rdata);
        bus.fetched_addr <= fl_addr[fl_rd];
      end
      if (bus.fetch_en && rq_full) bus.overflow     <= 1'b1;
      if (spurious)                bus.protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_insn_mem_bridge.sv
// Directed bench for insn_mem_bridge: cycle-indexed stimulus with hand-derived expectations.
module tb_insn_mem_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  insn_mem_bridge_if #(.ADDR_WIDTH(32), .INSN_WIDTH(32)) bus ();

  insn_mem_bridge #(.ADDR_WIDTH(32), .INSN_WIDTH(32), .REQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fe, input logic [31:0] fa, input logic fl,
                       input logic gnt, input logic rv, input logic [31:0] rd);
    bus.fetch_en   = fe;
    bus.fetch_addr = fa[29:0];
    bus.flush      = fl;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rd;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, " mem_req"},       64'(bus.mem_req),       64'h0);
    check({pfx, " mem_addr"},      64'(bus.mem_addr),      64'h0);
    check({pfx, " fetch_busy"},    64'(bus.fetch_busy),    64'h0);
    check({pfx, " fetched_valid"}, 64'(bus.fetched_valid), 64'h0);
    check({pfx, " fetched_insn"},  64'(bus.fetched_insn),  64'h0);
    check({pfx, " fetched_addr"},  64'(bus.fetched_addr),  64'h0);
    check({pfx, " overflow"},      64'(bus.overflow),      64'h0);
    check({pfx, " protocol_err"},  64'(bus.protocol_err),  64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic ev;
    logic [31:0] ea;

    // reset state
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // back-to-back fetch, no stalls
    for (int c = 0; c < 12; c++) begin
      drive(c < 8, 32'h100 + 32'(c), 1'b0, 1'b1, c >= 2 && c < 10, 32'hA000_0000 + 32'(c));
      ev = (c >= 1 && c < 9);
      ea = ev ? 32'h100 + 32'(c) - 32'd1 : 32'h0;
      check($sformatf("b2b mem_req c%0d", c),  64'(bus.mem_req),  64'(ev));
      check($sformatf("b2b mem_addr c%0d", c), 64'(bus.mem_addr), 64'(ea));
      ev = (c >= 3 && c < 11);
      check($sformatf("b2b valid c%0d", c), 64'(bus.fetched_valid), 64'(ev));
      if (ev) begin
        check($sformatf("b2b addr c%0d", c), 64'(bus.fetched_addr), 64'(32'h100 + 32'(c) - 32'd3));
        check($sformatf("b2b insn c%0d", c), 64'(bus.fetched_insn), 64'(32'hA000_0000 + 32'(c) - 32'd1));
      end
      check($sformatf("b2b busy c%0d", c), 64'(bus.fetch_busy), 64'h0);
      tick();
    end
    check("b2b overflow", 64'(bus.overflow), 64'h0);

    // grant stall with overflow
    apply_reset();
    for (int c = 0; c < 18; c++) begin
      drive(c < 6, 32'h300 + 32'(c), 1'b0, c >= 10, c >= 11 && c <= 14, 32'hB000_0000 + 32'(c));
      check($sformatf("stall busy c%0d", c), 64'(bus.fetch_busy), 64'(c >= 4 && c <= 10));
      check($sformatf("stall ovf c%0d", c),  64'(bus.overflow),   64'(c >= 5));
      ev = (c >= 1 && c <= 13);
      ea = !ev ? 32'h0 : (c <= 10 ? 32'h300 : 32'h300 + 32'(c) - 32'd10);
      check($sformatf("stall mem_req c%0d", c),  64'(bus.mem_req),  64'(ev));
      check($sformatf("stall mem_addr c%0d", c), 64'(bus.mem_addr), 64'(ea));
      ev = (c >= 12 && c <= 15);
      check($sformatf("stall valid c%0d", c), 64'(bus.fetched_valid), 64'(ev));
      if (ev) begin
        check($sformatf("stall addr c%0d", c), 64'(bus.fetched_addr), 64'(32'h300 + 32'(c) - 32'd12));
        check($sformatf("stall insn c%0d", c), 64'(bus.fetched_insn), 64'(32'hB000_0000 + 32'(c) - 32'd1));
      end
      tick();
    end

    // flush with three in flight plus a same-cycle fetch
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c < 3 || c == 4, (c == 4) ? 32'h200 : 32'h500 + 32'(c), c == 4, 1'b1,
            c >= 5 && c <= 8, 32'hD000_0000 + 32'(c));
      ev = (c >= 1 && c <= 3) || c == 5;
      ea = !ev ? 32'h0 : (c == 5 ? 32'h200 : 32'h500 + 32'(c) - 32'd1);
      check($sformatf("flush3 mem_req c%0d", c),  64'(bus.mem_req),  64'(ev));
      check($sformatf("flush3 mem_addr c%0d", c), 64'(bus.mem_addr), 64'(ea));
      check($sformatf("flush3 valid c%0d", c), 64'(bus.fetched_valid), 64'(c == 9));
      if (c == 9) begin
        check("flush3 addr", 64'(bus.fetched_addr), 64'h200);
        check("flush3 insn", 64'(bus.fetched_insn), 64'hD000_0008);
      end
      tick();
    end

    // flush coinciding with rvalid and with a grant; registered output survives a later flush
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      drive(c == 0 || c == 1 || c == 3, (c == 3) ? 32'h602 : 32'h600 + 32'(c),
            c == 2 || c == 6, 1'b1, c == 2 || c == 4 || c == 5, 32'hE000_0000 + 32'(c));
      ev = (c == 1 || c == 2 || c == 4);
      ea = !ev ? 32'h0 : (c == 4 ? 32'h602 : 32'h600 + 32'(c) - 32'd1);
      check($sformatf("fedge mem_req c%0d", c),  64'(bus.mem_req),  64'(ev));
      check($sformatf("fedge mem_addr c%0d", c), 64'(bus.mem_addr), 64'(ea));
      check($sformatf("fedge valid c%0d", c), 64'(bus.fetched_valid), 64'(c == 6));
      if (c == 6) begin
        check("fedge addr", 64'(bus.fetched_addr), 64'h602);
        check("fedge insn", 64'(bus.fetched_insn), 64'hE000_0005);
      end
      tick();
    end
    check("fedge protocol_err", 64'(bus.protocol_err), 64'h0);

    // spurious response sets a sticky error cleared only by reset
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, c == 0, 32'h1234_5678);
      check($sformatf("spur perr c%0d", c),  64'(bus.protocol_err),  64'(c >= 1));
      check($sformatf("spur valid c%0d", c), 64'(bus.fetched_valid), 64'h0);
      tick();
    end
    apply_reset();
    check("spur perr after rst", 64'(bus.protocol_err), 64'h0);

    // asynchronous reset with two in flight and one pending
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h700 + 32'(c), 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("arst pre mem_req",  64'(bus.mem_req),  64'h1);
    check("arst pre mem_addr", 64'(bus.mem_addr), 64'h702);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("arst");
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 32'h40, 1'b0, 1'b1, c == 0 || c == 2, 32'hC000_0000 + 32'(c));
      check($sformatf("arst perr c%0d", c),    64'(bus.protocol_err),  64'(c >= 1));
      check($sformatf("arst mem_req c%0d", c), 64'(bus.mem_req),       64'(c == 1));
      check($sformatf("arst valid c%0d", c),   64'(bus.fetched_valid), 64'(c == 3));
      if (c == 1) check("arst mem_addr", 64'(bus.mem_addr), 64'h40);
      if (c == 3) begin
        check("arst addr", 64'(bus.fetched_addr), 64'h40);
        check("arst insn", 64'(bus.fetched_insn), 64'hC000_0002);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
